// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Pipelined two's-complement add/subtract unit. The WIDTH-bit operation is
//   split into STAGES chunks of CHUNK = WIDTH/STAGES bits. Each register stage
//   adds one chunk and hands its carry to the next stage. Valid/ready
//   handshakes sit on both sides. All stages advance together whenever the
//   output slot is empty or being consumed, which sustains one beat per clock.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat present            in_ready   unit accepts beat
//   a, b       operands (WIDTH)                sub        1: a-b, 0: a+b+carry_in
//   carry_in   carry into bit 0 for add
//   out_valid  result beat present             out_ready  consumer accepts
//   sum        result modulo 2^WIDTH           carry_out  carry out of MSB
//   overflow   signed overflow                 zero       sum == 0
// -----------------------------------------------------------------------------
module pipelined_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CHUNK = WIDTH / STAGES;
   localparam int LAST  = STAGES - 1;

   if ((WIDTH < 2) || (STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_param_check
      $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES");
   end

   // One chunk of the carry chain: {carry_out, sum} of x + y + cin.
   function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                input logic [CHUNK-1:0] y,
                                                input logic             cin);
      add_chunk = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
   endfunction

   // Stage k register holds the full operands it consumed (b already
   // conditioned for subtract), the sum bits produced so far, and its
   // chunk carry. Empty stages hold all zeros.
   logic             v_q     [STAGES];
   logic             v_d     [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic             carry_q [STAGES];
   logic             carry_d [STAGES];
   logic             ovf_q;
   logic             ovf_d;
   logic             zero_q;
   logic             zero_d;

   logic             adv_s;
   logic             accept_s;
   logic             c0_s;
   logic [WIDTH-1:0] b_eff_s;

   // The whole pipe moves as one unit: bubbles are not squeezed out while stalled.
   assign adv_s     = ~v_q[LAST] | out_ready;
   assign in_ready  = adv_s & ~rst;
   assign accept_s  = in_valid & in_ready;

   assign out_valid = v_q[LAST];
   assign sum       = sum_q[LAST];
   assign carry_out = carry_q[LAST];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

   // Next state for every stage: stage 0 captures a new beat, later stages add their chunk.
   always_comb begin
      b_eff_s    = sub ? ~b : b;
      c0_s       = sub ? 1'b1 : carry_in;

      v_d[0]     = accept_s;
      a_d[0]     = {WIDTH{1'b0}};
      b_d[0]     = {WIDTH{1'b0}};
      sum_d[0]   = {WIDTH{1'b0}};
      carry_d[0] = 1'b0;
      if (accept_s) begin
         a_d[0] = a;
         b_d[0] = b_eff_s;
         {carry_d[0], sum_d[0][CHUNK-1:0]} =
            add_chunk(a[CHUNK-1:0], b_eff_s[CHUNK-1:0], c0_s);
      end else begin
         carry_d[0] = 1'b0;
      end

      for (int k = 1; k < STAGES; k++) begin
         v_d[k]     = v_q[k-1];
         a_d[k]     = {WIDTH{1'b0}};
         b_d[k]     = {WIDTH{1'b0}};
         sum_d[k]   = {WIDTH{1'b0}};
         carry_d[k] = 1'b0;
         if (v_q[k-1]) begin
            a_d[k]   = a_q[k-1];
            b_d[k]   = b_q[k-1];
            sum_d[k] = sum_q[k-1];
            {carry_d[k], sum_d[k][k*CHUNK +: CHUNK]} =
               add_chunk(a_q[k-1][k*CHUNK +: CHUNK], b_q[k-1][k*CHUNK +: CHUNK], carry_q[k-1]);
         end else begin
            carry_d[k] = 1'b0;
         end
      end

      // Flags come from the final stage's inputs so they register alongside sum.
      // b_d already holds ~b for subtract, so its MSB is the effective sign.
      ovf_d  = v_d[LAST]
             & (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1])
             & (sum_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
      zero_d = v_d[LAST] & ~|sum_d[LAST];
   end

   // Pipeline registers: clear on reset, shift every stage together on advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]     <= 1'b0;
            a_q[k]     <= {WIDTH{1'b0}};
            b_q[k]     <= {WIDTH{1'b0}};
            sum_q[k]   <= {WIDTH{1'b0}};
            carry_q[k] <= 1'b0;
         end
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (adv_s) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k]     <= v_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
         end
         ovf_q  <= ovf_d;
         zero_q <= zero_d;
      end
   end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Drives three pipelined_addsub instances (8/2, 16/4, 8/1) from one shared
//   stimulus bus. Each instance has its own scoreboard, which is fed by an
//   arithmetic reference model. Directed tables and sequences cover latency,
//   back-to-back throughput, backpressure and reset.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        sub;
   logic        cin;
   logic [15:0] a16;
   logic [15:0] b16;

   logic        d0_in_ready, d0_out_valid, d0_carry, d0_ovf, d0_zero;
   logic [7:0]  d0_sum;
   logic        d1_in_ready, d1_out_valid, d1_carry, d1_ovf, d1_zero;
   logic [15:0] d1_sum;
   logic        d2_in_ready, d2_out_valid, d2_carry, d2_ovf, d2_zero;
   logic [7:0]  d2_sum;

   always #5 clk = ~clk;

   pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d0_in_ready),
      .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .carry_in(cin),
      .out_valid(d0_out_valid), .out_ready(out_ready), .sum(d0_sum),
      .carry_out(d0_carry), .overflow(d0_ovf), .zero(d0_zero));

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready),
      .a(a16), .b(b16), .sub(sub), .carry_in(cin),
      .out_valid(d1_out_valid), .out_ready(out_ready), .sum(d1_sum),
      .carry_out(d1_carry), .overflow(d1_ovf), .zero(d1_zero));

   pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
      .a(a16[7:0]), .b(b16[7:0]), .sub(sub), .carry_in(cin),
      .out_valid(d2_out_valid), .out_ready(out_ready), .sum(d2_sum),
      .carry_out(d2_carry), .overflow(d2_ovf), .zero(d2_zero));

   typedef struct {
      logic [15:0] sum;
      logic        carry;
      logic        ovf;
      logic        zero;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       sub;
      logic       cin;
      logic [7:0] sum;
      logic       c;
      logic       o;
      logic       z;
   } vec_t;

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q [3][$];
   logic stall_r [3];
   exp_t hold_r [3];
   vec_t tab [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic exp_t model(input logic [15:0] ai, input logic [15:0] bi,
                                  input logic s, input logic ci, input int w);
      exp_t   m;
      longint mask, half, ua, ub, sa, sb, u, r;
      mask = (longint'(1) << w) - 1;
      half = longint'(1) << (w - 1);
      ua   = longint'(ai) & mask;
      ub   = longint'(bi) & mask;
      sa   = (ua >= half) ? ua - 2 * half : ua;
      sb   = (ub >= half) ? ub - 2 * half : ub;
      if (s) begin
         u       = ua - ub;
         r       = sa - sb;
         m.carry = (ua >= ub);
      end else begin
         u       = ua + ub + longint'(ci);
         r       = sa + sb + longint'(ci);
         m.carry = (u > mask);
      end
      m.sum  = 16'(u & mask);
      m.ovf  = (r >= half) || (r < -half);
      m.zero = ((u & mask) == 0);
      return m;
   endfunction

   // Per-instance scoreboard step, called once per falling edge.
   task automatic mon(input int id, input logic ir, input logic ov, input logic [15:0] s,
                      input logic c, input logic o, input logic z, input int w);
      exp_t  e;
      string nm;
      nm = $sformatf("d%0d", id);
      if (rst) begin
         chk({nm, ".in_ready_in_reset"}, ir, 0);
         sb_q[id].delete();
         stall_r[id] = 1'b0;
      end else begin
         if (stall_r[id]) begin
            chk({nm, ".stall_valid"}, ov, 1);
            chk({nm, ".stall_sum"},   s,  hold_r[id].sum);
            chk({nm, ".stall_carry"}, c,  hold_r[id].carry);
            chk({nm, ".stall_ovf"},   o,  hold_r[id].ovf);
            chk({nm, ".stall_zero"},  z,  hold_r[id].zero);
         end
         if (ov && out_ready) begin
            if (sb_q[id].size() == 0) begin
               total++;
               bad++;
               $display("FAIL %s.unexpected_result: got sum 0x%0h, want no result at %0t", nm, s, $time);
            end else begin
               e = sb_q[id].pop_front();
               chk({nm, ".sum"},   s, e.sum);
               chk({nm, ".carry"}, c, e.carry);
               chk({nm, ".ovf"},   o, e.ovf);
               chk({nm, ".zero"},  z, e.zero);
            end
         end
         if (in_valid && ir) begin
            sb_q[id].push_back(model(a16, b16, sub, cin, w));
         end
         stall_r[id] = ov && !out_ready;
         hold_r[id]  = '{sum: s, carry: c, ovf: o, zero: z};
      end
   endtask

   always @(negedge clk) begin
      mon(0, d0_in_ready, d0_out_valid, {8'h00, d0_sum}, d0_carry, d0_ovf, d0_zero, 8);
      mon(1, d1_in_ready, d1_out_valid, d1_sum,          d1_carry, d1_ovf, d1_zero, 16);
      mon(2, d2_in_ready, d2_out_valid, {8'h00, d2_sum}, d2_carry, d2_ovf, d2_zero, 8);
   end

   task automatic rand_beat();
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a16 = 16'h0000; b16 = 16'h0000; sub = 1'b0; cin = 1'b0;

      //           a      b      sub   cin   sum    c     o     z
      tab[0] = '{8'h02, 8'h02, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0};
      tab[1] = '{8'h92, 8'hAB, 1'b0, 1'b0, 8'h3D, 1'b1, 1'b1, 1'b0};
      tab[2] = '{8'h92, 8'hAB, 1'b0, 1'b1, 8'h3E, 1'b1, 1'b1, 1'b0};
      tab[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
      tab[4] = '{8'h10, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      tab[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
      tab[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0};
      tab[7] = '{8'hFF, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
      tab[8] = '{8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
      tab[9] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst.d0_out_valid", d0_out_valid, 0);
      chk("rst.d0_sum",       d0_sum,       0);
      chk("rst.d0_flags",     {d0_carry, d0_ovf, d0_zero}, 0);
      chk("rst.d1_out_valid", d1_out_valid, 0);
      chk("rst.d1_sum",       d1_sum,       0);
      chk("rst.d1_flags",     {d1_carry, d1_ovf, d1_zero}, 0);
      chk("rst.d2_out_valid", d2_out_valid, 0);
      chk("rst.d2_flags",     {d2_sum, d2_carry, d2_ovf, d2_zero}, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst.release_in_ready", {d0_in_ready, d1_in_ready, d2_in_ready}, 3'b111);

      // Directed vectors with latency check per configuration
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         a16 = {8'h00, tab[i].a};
         b16 = {8'h00, tab[i].b};
         sub = tab[i].sub;
         cin = tab[i].cin;
         @(posedge clk); #1 in_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("tab%0d.d2_valid", i), d2_out_valid, 1);
         chk($sformatf("tab%0d.d2_sum", i), d2_sum, tab[i].sum);
         chk($sformatf("tab%0d.d2_flags", i), {d2_carry, d2_ovf, d2_zero}, {tab[i].c, tab[i].o, tab[i].z});
         chk($sformatf("tab%0d.d0_early", i), d0_out_valid, 0);
         @(negedge clk);
         chk($sformatf("tab%0d.d0_valid", i), d0_out_valid, 1);
         chk($sformatf("tab%0d.d0_sum", i), d0_sum, tab[i].sum);
         chk($sformatf("tab%0d.d0_flags", i), {d0_carry, d0_ovf, d0_zero}, {tab[i].c, tab[i].o, tab[i].z});
         @(negedge clk);
         chk($sformatf("tab%0d.d1_early", i), d1_out_valid, 0);
         @(negedge clk);
         chk($sformatf("tab%0d.d1_valid", i), d1_out_valid, 1);
      end

      // Back-to-back: 8 beats on consecutive clocks, results on consecutive clocks
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         in_valid = (i < 8);
         rand_beat();
         @(negedge clk);
         if (i < 8) chk($sformatf("b2b%0d.in_ready", i), d0_in_ready, 1);
         chk($sformatf("b2b%0d.d0_valid", i), d0_out_valid, (i >= 2));
      end
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (6) @(posedge clk);

      // Backpressure: results held for 5 clocks, then released
      #1 out_ready = 1'b0; in_valid = 1'b1; rand_beat();
      @(posedge clk); #1 rand_beat();
      @(posedge clk); #1 rand_beat();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("bp%0d.d0_in_ready", i), d0_in_ready, 0);
         chk($sformatf("bp%0d.d0_valid", i), d0_out_valid, 1);
         @(posedge clk); #1 rand_beat();
      end
      out_ready = 1'b1; in_valid = 1'b0;
      repeat (8) @(posedge clk);

      // Reset with two beats in flight
      #1 in_valid = 1'b1; rand_beat();
      @(posedge clk); #1 rand_beat();
      @(posedge clk); #1 in_valid = 1'b0; rst = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      chk("midrst.d0_out_valid_pre", d0_out_valid, 1);
      @(negedge clk);
      chk("midrst.out_valid", {d0_out_valid, d1_out_valid, d2_out_valid}, 3'b000);
      @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("midrst.in_ready_after", {d0_in_ready, d1_in_ready, d2_in_ready}, 3'b111);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("midrst%0d.no_stale", i), {d0_out_valid, d1_out_valid, d2_out_valid}, 3'b000);
      end

      // Random traffic with random backpressure
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         rand_beat();
         if ($urandom_range(0, 7) == 0) a16 = 16'hFFFF;
         if ($urandom_range(0, 7) == 0) b16 = (a16 ^ 16'h0000);
      end
      @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      for (int id = 0; id < 3; id++) begin
         chk($sformatf("d%0d.leftover", id), sb_q[id].size(), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
